aes_inv_key_sched: RTL and testbench

- AES-128 inverse key scheduler for the decryption datapath.
- Produces the eleven round keys in reverse order, round 10 down to round 0, one per accepted handshake.
- Accepts either the cipher key, which it first expands forward internally for 10 cycles, or the round-10 key directly.
- Sits between the key register and the inverse-cipher round logic. Uses the existing combinational SBox module (ports addr[7:0], dout[7:0]) for SubWord.

---
 rtl/aes_inv_key_sched.sv | 158 +++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key scheduler: emits round keys 10 down to 0, one per handshake,
// optionally expanding the cipher key forward first. Includes the shared SBox lookup.

module SBox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX_TABLE[addr];
endmodule

module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         key_is_last,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    logic [1:0]  state;
    logic [3:0]  fwd_cnt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] inv_w1, inv_w2, inv_w3;
    logic [31:0] sbox_in, rot_word, sub_word, rcon_word;
    logic [3:0]  rcon_round;
    logic [127:0] fwd_key, inv_key;
    logic [31:0] f0, f1, f2, f3, i0;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;

    // The four SBoxes are shared: forward expansion feeds w3, output phase feeds the undone w3.
    assign sbox_in    = (state == FWD) ? w3 : inv_w3;
    assign rot_word   = {sbox_in[23:0], sbox_in[31:24]};
    assign rcon_round = (state == FWD) ? fwd_cnt : round_idx;
    assign rcon_word  = {rcon(rcon_round), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        SBox u_sbox (
            .addr (rot_word[8*i +: 8]),
            .dout (sub_word[8*i +: 8])
        );
    end

    assign f0 = w0 ^ sub_word ^ rcon_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign i0 = w0 ^ sub_word ^ rcon_word;
    assign inv_key = {i0, inv_w1, inv_w2, inv_w3};

    assign key_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            fwd_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        if (key_is_last) begin
                            round_idx <= LAST_IDX;
                            state     <= OUT;
                        end else begin
                            round_idx <= 4'd0;
                            fwd_cnt   <= 4'd1;
                            state     <= FWD;
                        end
                    end
                end
                FWD: begin
                    round_key <= fwd_key;
                    round_idx <= fwd_cnt;
                    fwd_cnt   <= fwd_cnt + 4'd1;
                    if (fwd_cnt == LAST_IDX) begin
                        fwd_cnt <= 4'd0;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (key_ready) begin
                        if (round_idx != 4'd0) begin
                            round_key <= inv_key;
                            round_idx <= round_idx - 4'd1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 and all-zero key expansions.

module tb_aes_inv_key_sched;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic         key_is_last;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];
    logic [127:0] exp_rk  [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;

    aes_inv_key_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_is_last (key_is_last),
        .key_in      (key_in),
        .key_ready   (key_ready),
        .round_key   (round_key),
        .round_idx   (round_idx),
        .key_valid   (key_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic last, input logic [127:0] key);
        start       = s;
        key_is_last = last;
        key_in      = key;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_key"},   round_key, 128'd0);
        checkOutput({tag, "_idx"},   128'(round_idx), 128'd0);
        checkOutput({tag, "_valid"}, 128'(key_valid), 128'd0);
        checkOutput({tag, "_busy"},  128'(busy), 128'd0);
        checkOutput({tag, "_done"},  128'(done), 128'd0);
    endtask

    task automatic loadExpected(input bit use_zero);
        for (int i = 0; i <= 10; i++)
            exp_rk[i] = use_zero ? zero_rk[i] : fips_rk[i];
    endtask

    // Launches a schedule; for a cipher key, also checks the 10 silent expansion cycles.
    task automatic startSchedule(input logic last, input logic [127:0] key, input bit inject_fwd);
        applyStimulus(1'b1, last, key);
        tick;
        applyStimulus(1'b0, ~last, ALT_KEY);
        if (!last) begin
            for (int i = 1; i <= 10; i++) begin
                checkOutput("fwd_valid_low", 128'(key_valid), 128'd0);
                checkOutput("fwd_busy", 128'(busy), 128'd1);
                if (inject_fwd && i == 5) applyStimulus(1'b1, 1'b1, ALT_KEY);
                tick;
                if (inject_fwd && i == 5) applyStimulus(1'b0, 1'b0, ALT_KEY);
            end
        end
    endtask

    task automatic drainKeys(input int stall_idx, input bit random_stalls, input bit inject, input int stop_at);
        int n;
        for (int k = 10; k >= 0; k--) begin
            checkOutput("out_valid", 128'(key_valid), 128'd1);
            checkOutput("out_idx", 128'(round_idx), 128'(k));
            checkOutput("out_key", round_key, exp_rk[k]);
            checkOutput("out_done_low", 128'(done), 128'd0);
            if (k == stop_at) return;
            if (k == stall_idx || (random_stalls && $urandom_range(0, 3) == 0)) begin
                n = (k == stall_idx) ? 3 : 1;
                key_ready = 1'b0;
                for (int s = 0; s < n; s++) begin
                    tick;
                    checkOutput("stall_idx", 128'(round_idx), 128'(k));
                    checkOutput("stall_key", round_key, exp_rk[k]);
                    checkOutput("stall_valid", 128'(key_valid), 128'd1);
                end
                key_ready = 1'b1;
            end
            if (inject && (k == 8 || k == 0)) applyStimulus(1'b1, 1'b1, ALT_KEY);
            tick;
            if (inject && (k == 8 || k == 0)) applyStimulus(1'b0, 1'b0, ALT_KEY);
        end
        checkOutput("done_pulse", 128'(done), 128'd1);
        checkOutput("done_valid_low", 128'(key_valid), 128'd0);
        checkOutput("done_busy_low", 128'(busy), 128'd0);
        tick;
        checkOutput("done_single", 128'(done), 128'd0);
        checkOutput("idle_busy_low", 128'(busy), 128'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        zero_rk[0]  = 128'h00000000000000000000000000000000;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n     = 1'b0;
        key_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 128'd0);
        tick;
        tick;
        checkIdleZero("reset");
        rst_n = 1'b1;
        tick;
        checkOutput("post_reset_busy", 128'(busy), 128'd0);

        // Cipher key expanded forward, then walked back with the consumer always ready.
        loadExpected(1'b0);
        startSchedule(1'b0, FIPS_KEY, 1'b0);
        drainKeys(-1, 1'b0, 1'b0, -1);

        // Round-10 key loaded directly, with a 3-cycle stall at round 7 and random stalls.
        startSchedule(1'b1, FIPS_R10, 1'b0);
        drainKeys(7, 1'b1, 1'b0, -1);

        // Stray starts during FWD and OUT are ignored; a start right after done relaunches.
        startSchedule(1'b0, FIPS_KEY, 1'b1);
        drainKeys(-1, 1'b0, 1'b1, -1);
        startSchedule(1'b1, FIPS_R10, 1'b0);
        drainKeys(-1, 1'b0, 1'b0, -1);

        // Reset mid-expansion.
        applyStimulus(1'b1, 1'b0, FIPS_KEY);
        tick;
        applyStimulus(1'b0, 1'b0, 128'd0);
        tick;
        tick;
        checkOutput("fwd_busy_before_reset", 128'(busy), 128'd1);
        rst_n = 1'b0;
        tick;
        checkIdleZero("reset_fwd");
        rst_n = 1'b1;
        tick;
        checkOutput("reset_fwd_no_done", 128'(done), 128'd0);

        // Reset while presenting round 5.
        startSchedule(1'b1, FIPS_R10, 1'b0);
        drainKeys(-1, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        tick;
        checkIdleZero("reset_out");
        rst_n = 1'b1;
        tick;
        checkOutput("reset_out_no_done", 128'(done), 128'd0);
        checkOutput("reset_out_busy", 128'(busy), 128'd0);

        // All-zero cipher key after the aborted runs.
        loadExpected(1'b1);
        startSchedule(1'b0, 128'd0, 1'b0);
        drainKeys(-1, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
